// File: rtl/pcie_rd_tag_tracker.sv
// Joins read requests with allocator tags, tracks outstanding completion DWs per tag,
// and returns finished tags to the allocator while reporting done events to the DMA engine.
module pcie_rd_tag_tracker #(
   parameter int unsigned PCIE_TAG_BITS = 5,
   parameter int unsigned LEN_BITS      = 10,
   parameter int unsigned ADDR_BITS     = 32,
   parameter int unsigned CTX_BITS      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alloc_core_ready,
   input  logic [ADDR_BITS-1:0]     s_req_addr,
   input  logic [LEN_BITS-1:0]      s_req_len,
   input  logic [CTX_BITS-1:0]      s_req_ctx,
   input  logic                     s_req_valid,
   output logic                     s_req_ready,
   input  logic [PCIE_TAG_BITS-1:0] s_tag_data,
   input  logic                     s_tag_valid,
   output logic                     s_tag_ready,
   output logic [PCIE_TAG_BITS-1:0] m_rdreq_tag,
   output logic [ADDR_BITS-1:0]     m_rdreq_addr,
   output logic [LEN_BITS-1:0]      m_rdreq_len,
   output logic                     m_rdreq_valid,
   input  logic                     m_rdreq_ready,
   input  logic [PCIE_TAG_BITS-1:0] s_cpl_tag,
   input  logic [LEN_BITS-1:0]      s_cpl_len,
   input  logic                     s_cpl_valid,
   output logic                     s_cpl_ready,
   output logic [PCIE_TAG_BITS-1:0] m_tag_free_data,
   output logic                     m_tag_free_valid,
   input  logic                     m_tag_free_ready,
   output logic [PCIE_TAG_BITS-1:0] m_done_tag,
   output logic [CTX_BITS-1:0]      m_done_ctx,
   output logic                     m_done_err,
   output logic                     m_done_valid,
   input  logic                     m_done_ready,
   output logic [PCIE_TAG_BITS:0]   outstanding,
   output logic                     err_unexpected,
   output logic                     err_overrun
);

   localparam int unsigned Depth   = 1 << PCIE_TAG_BITS;
   localparam int unsigned RemBits = LEN_BITS + 1;
   localparam logic [PCIE_TAG_BITS:0] OneCnt = 1;

   function automatic logic [RemBits-1:0] expand(input logic [LEN_BITS-1:0] x);
      return (x == '0) ? {1'b1, {LEN_BITS{1'b0}}} : {1'b0, x};
   endfunction

   logic [Depth-1:0]    valid_q, valid_d;
   logic [RemBits-1:0]  rem_q [Depth];
   logic [RemBits-1:0]  rem_d [Depth];
   logic [CTX_BITS-1:0] ctx_q [Depth];
   logic [CTX_BITS-1:0] ctx_d [Depth];

   logic [PCIE_TAG_BITS-1:0] rdreq_tag_q, rdreq_tag_d;
   logic [ADDR_BITS-1:0]     rdreq_addr_q, rdreq_addr_d;
   logic [LEN_BITS-1:0]      rdreq_len_q, rdreq_len_d;
   logic                     rdreq_valid_q, rdreq_valid_d;
   logic [PCIE_TAG_BITS-1:0] free_data_q, free_data_d;
   logic                     free_valid_q, free_valid_d;
   logic [PCIE_TAG_BITS-1:0] done_tag_q, done_tag_d;
   logic [CTX_BITS-1:0]      done_ctx_q, done_ctx_d;
   logic                     done_err_q, done_err_d;
   logic                     done_valid_q, done_valid_d;
   logic [PCIE_TAG_BITS:0]   outstanding_q, outstanding_d;
   logic                     err_unexp_q, err_unexp_d;
   logic                     err_over_q, err_over_d;

   logic               issue_fire, cpl_fire, cpl_hit, cpl_final, cpl_over, inc, dec;
   logic [RemBits-1:0] cpl_rem, cpl_exp;

   assign issue_fire = alloc_core_ready && s_req_valid && s_tag_valid &&
                       (!rdreq_valid_q || m_rdreq_ready);
   assign s_req_ready = issue_fire;
   assign s_tag_ready = issue_fire;

   assign s_cpl_ready = (!free_valid_q || m_tag_free_ready) && (!done_valid_q || m_done_ready);
   assign cpl_fire    = s_cpl_valid && s_cpl_ready;
   assign cpl_hit     = valid_q[s_cpl_tag];
   assign cpl_rem     = rem_q[s_cpl_tag];
   assign cpl_exp     = expand(s_cpl_len);
   assign cpl_final   = cpl_exp >= cpl_rem;
   assign cpl_over    = cpl_exp > cpl_rem;

   // A reissue onto a still-valid tag overwrites the entry without counting twice.
   assign inc = issue_fire && !valid_q[s_tag_data];
   assign dec = cpl_fire && cpl_hit && cpl_final;

   always_comb begin
      valid_d = valid_q;
      rem_d   = rem_q;
      ctx_d   = ctx_q;
      if (cpl_fire && cpl_hit) begin
         if (cpl_final) valid_d[s_cpl_tag] = 1'b0;
         else           rem_d[s_cpl_tag]   = cpl_rem - cpl_exp;
      end
      if (issue_fire) begin
         valid_d[s_tag_data] = 1'b1;
         rem_d[s_tag_data]   = expand(s_req_len);
         ctx_d[s_tag_data]   = s_req_ctx;
      end
   end

   always_comb begin
      rdreq_tag_d   = rdreq_tag_q;
      rdreq_addr_d  = rdreq_addr_q;
      rdreq_len_d   = rdreq_len_q;
      rdreq_valid_d = rdreq_valid_q && !m_rdreq_ready;
      if (issue_fire) begin
         rdreq_tag_d   = s_tag_data;
         rdreq_addr_d  = s_req_addr;
         rdreq_len_d   = s_req_len;
         rdreq_valid_d = 1'b1;
      end

      free_data_d  = free_data_q;
      free_valid_d = free_valid_q && !m_tag_free_ready;
      done_tag_d   = done_tag_q;
      done_ctx_d   = done_ctx_q;
      done_err_d   = done_err_q;
      done_valid_d = done_valid_q && !m_done_ready;
      if (dec) begin
         free_data_d  = s_cpl_tag;
         free_valid_d = 1'b1;
         done_tag_d   = s_cpl_tag;
         done_ctx_d   = ctx_q[s_cpl_tag];
         done_err_d   = cpl_over;
         done_valid_d = 1'b1;
      end

      unique case ({inc, dec})
         2'b10:   outstanding_d = outstanding_q + OneCnt;
         2'b01:   outstanding_d = outstanding_q - OneCnt;
         default: outstanding_d = outstanding_q;
      endcase

      err_unexp_d = cpl_fire && !cpl_hit;
      err_over_d  = cpl_fire && cpl_hit && cpl_over;
   end

   // Payload storage needs no reset; only the valid bits gate its use.
   always_ff @(posedge clk) begin
      rem_q <= rem_d;
      ctx_q <= ctx_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q       <= '0;
         rdreq_tag_q   <= '0;
         rdreq_addr_q  <= '0;
         rdreq_len_q   <= '0;
         rdreq_valid_q <= 1'b0;
         free_data_q   <= '0;
         free_valid_q  <= 1'b0;
         done_tag_q    <= '0;
         done_ctx_q    <= '0;
         done_err_q    <= 1'b0;
         done_valid_q  <= 1'b0;
         outstanding_q <= '0;
         err_unexp_q   <= 1'b0;
         err_over_q    <= 1'b0;
      end else begin
         valid_q       <= valid_d;
         rdreq_tag_q   <= rdreq_tag_d;
         rdreq_addr_q  <= rdreq_addr_d;
         rdreq_len_q   <= rdreq_len_d;
         rdreq_valid_q <= rdreq_valid_d;
         free_data_q   <= free_data_d;
         free_valid_q  <= free_valid_d;
         done_tag_q    <= done_tag_d;
         done_ctx_q    <= done_ctx_d;
         done_err_q    <= done_err_d;
         done_valid_q  <= done_valid_d;
         outstanding_q <= outstanding_d;
         err_unexp_q   <= err_unexp_d;
         err_over_q    <= err_over_d;
      end
   end

   assign m_rdreq_tag      = rdreq_tag_q;
   assign m_rdreq_addr     = rdreq_addr_q;
   assign m_rdreq_len      = rdreq_len_q;
   assign m_rdreq_valid    = rdreq_valid_q;
   assign m_tag_free_data  = free_data_q;
   assign m_tag_free_valid = free_valid_q;
   assign m_done_tag       = done_tag_q;
   assign m_done_ctx       = done_ctx_q;
   assign m_done_err       = done_err_q;
   assign m_done_valid     = done_valid_q;
   assign outstanding      = outstanding_q;
   assign err_unexpected   = err_unexp_q;
   assign err_overrun      = err_over_q;

endmodule

// File: tb/tb_pcie_rd_tag_tracker.sv
// Scenario bench for pcie_rd_tag_tracker: expected issued requests, frees and done events are
// queued as stimulus is driven and compared as the DUT hands them off.
module tb_pcie_rd_tag_tracker;

   typedef struct packed {
      logic [4:0]  tag;
      logic [31:0] addr;
      logic [9:0]  len;
   } rdreq_t;

   typedef struct packed {
      logic [4:0]  tag;
      logic [15:0] ctx;
      logic        err;
   } done_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alloc_core_ready = 1'b0;
   logic [31:0] s_req_addr = '0;
   logic [9:0]  s_req_len = '0;
   logic [15:0] s_req_ctx = '0;
   logic        s_req_valid = 1'b0;
   logic        s_req_ready;
   logic [4:0]  s_tag_data = '0;
   logic        s_tag_valid = 1'b0;
   logic        s_tag_ready;
   logic [4:0]  m_rdreq_tag;
   logic [31:0] m_rdreq_addr;
   logic [9:0]  m_rdreq_len;
   logic        m_rdreq_valid;
   logic        m_rdreq_ready = 1'b1;
   logic [4:0]  s_cpl_tag = '0;
   logic [9:0]  s_cpl_len = '0;
   logic        s_cpl_valid = 1'b0;
   logic        s_cpl_ready;
   logic [4:0]  m_tag_free_data;
   logic        m_tag_free_valid;
   logic        m_tag_free_ready = 1'b1;
   logic [4:0]  m_done_tag;
   logic [15:0] m_done_ctx;
   logic        m_done_err;
   logic        m_done_valid;
   logic        m_done_ready = 1'b1;
   logic [5:0]  outstanding;
   logic        err_unexpected;
   logic        err_overrun;

   int total = 0;
   int bad = 0;

   rdreq_t     rdreq_sb[$];
   logic [4:0] free_sb[$];
   done_t      done_sb[$];
   rdreq_t     rd_exp;
   logic [4:0] fr_exp;
   done_t      dn_exp;

   pcie_rd_tag_tracker dut (
      .clk              (clk),
      .rst              (rst),
      .alloc_core_ready (alloc_core_ready),
      .s_req_addr       (s_req_addr),
      .s_req_len        (s_req_len),
      .s_req_ctx        (s_req_ctx),
      .s_req_valid      (s_req_valid),
      .s_req_ready      (s_req_ready),
      .s_tag_data       (s_tag_data),
      .s_tag_valid      (s_tag_valid),
      .s_tag_ready      (s_tag_ready),
      .m_rdreq_tag      (m_rdreq_tag),
      .m_rdreq_addr     (m_rdreq_addr),
      .m_rdreq_len      (m_rdreq_len),
      .m_rdreq_valid    (m_rdreq_valid),
      .m_rdreq_ready    (m_rdreq_ready),
      .s_cpl_tag        (s_cpl_tag),
      .s_cpl_len        (s_cpl_len),
      .s_cpl_valid      (s_cpl_valid),
      .s_cpl_ready      (s_cpl_ready),
      .m_tag_free_data  (m_tag_free_data),
      .m_tag_free_valid (m_tag_free_valid),
      .m_tag_free_ready (m_tag_free_ready),
      .m_done_tag       (m_done_tag),
      .m_done_ctx       (m_done_ctx),
      .m_done_err       (m_done_err),
      .m_done_valid     (m_done_valid),
      .m_done_ready     (m_done_ready),
      .outstanding      (outstanding),
      .err_unexpected   (err_unexpected),
      .err_overrun      (err_overrun)
   );

   always #5 clk = ~clk;

   // Output monitor: handshakes are judged on the falling edge before the rising edge that takes them.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_rdreq_valid && m_rdreq_ready) begin
            total++;
            if (rdreq_sb.size() == 0) begin
               bad++;
               $display("FAIL rdreq_extra: got tag=%0d addr=%h len=%0d, none expected",
                        m_rdreq_tag, m_rdreq_addr, m_rdreq_len);
            end else begin
               rd_exp = rdreq_sb.pop_front();
               if ({m_rdreq_tag, m_rdreq_addr, m_rdreq_len} !== rd_exp) begin
                  bad++;
                  $display("FAIL rdreq: got tag=%0d addr=%h len=%0d, want tag=%0d addr=%h len=%0d",
                           m_rdreq_tag, m_rdreq_addr, m_rdreq_len,
                           rd_exp.tag, rd_exp.addr, rd_exp.len);
               end
            end
         end
         if (m_tag_free_valid && m_tag_free_ready) begin
            total++;
            if (free_sb.size() == 0) begin
               bad++;
               $display("FAIL free_extra: got tag=%0d, none expected", m_tag_free_data);
            end else begin
               fr_exp = free_sb.pop_front();
               if (m_tag_free_data !== fr_exp) begin
                  bad++;
                  $display("FAIL free: got tag=%0d, want %0d", m_tag_free_data, fr_exp);
               end
            end
         end
         if (m_done_valid && m_done_ready) begin
            total++;
            if (done_sb.size() == 0) begin
               bad++;
               $display("FAIL done_extra: got tag=%0d ctx=%h err=%0d, none expected",
                        m_done_tag, m_done_ctx, m_done_err);
            end else begin
               dn_exp = done_sb.pop_front();
               if ({m_done_tag, m_done_ctx, m_done_err} !== dn_exp) begin
                  bad++;
                  $display("FAIL done: got tag=%0d ctx=%h err=%0d, want tag=%0d ctx=%h err=%0d",
                           m_done_tag, m_done_ctx, m_done_err, dn_exp.tag, dn_exp.ctx, dn_exp.err);
               end
            end
         end
      end
   end

   task automatic do_issue(input logic [4:0] tag, input logic [31:0] addr, input logic [9:0] len,
                           input logic [15:0] ctx);
      int n = 0;
      s_tag_data  = tag;
      s_req_addr  = addr;
      s_req_len   = len;
      s_req_ctx   = ctx;
      s_req_valid = 1'b1;
      s_tag_valid = 1'b1;
      @(negedge clk);
      while (!s_req_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      total++;
      if (!s_req_ready || !s_tag_ready) begin
         bad++;
         $display("FAIL issue_accept tag=%0d: req_ready=%0d tag_ready=%0d, want 1/1",
                  tag, s_req_ready, s_tag_ready);
      end else begin
         rdreq_sb.push_back({tag, addr, len});
      end
      @(posedge clk);
      #1;
      s_req_valid = 1'b0;
      s_tag_valid = 1'b0;
   endtask

   task automatic do_cpl(input logic [4:0] tag, input logic [9:0] len);
      int n = 0;
      s_cpl_tag   = tag;
      s_cpl_len   = len;
      s_cpl_valid = 1'b1;
      @(negedge clk);
      while (!s_cpl_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      total++;
      if (!s_cpl_ready) begin
         bad++;
         $display("FAIL cpl_accept tag=%0d: cpl_ready=0, want 1", tag);
      end
      @(posedge clk);
      #1;
      s_cpl_valid = 1'b0;
   endtask

   task automatic test_reset();
      s_req_valid = 1'b1;
      s_tag_valid = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if ({m_rdreq_valid, m_tag_free_valid, m_done_valid, err_unexpected, err_overrun} !== 5'b0) begin
         bad++;
         $display("FAIL reset_valids: got %b, want 00000",
                  {m_rdreq_valid, m_tag_free_valid, m_done_valid, err_unexpected, err_overrun});
      end
      total++;
      if (outstanding !== 6'd0 || m_rdreq_addr !== 32'd0 || m_done_ctx !== 16'd0) begin
         bad++;
         $display("FAIL reset_data: outstanding=%0d addr=%h ctx=%h, want 0", outstanding,
                  m_rdreq_addr, m_done_ctx);
      end
      total++;
      if (s_req_ready !== 1'b0 || s_tag_ready !== 1'b0) begin
         bad++;
         $display("FAIL core_not_ready: req_ready=%0d tag_ready=%0d, want 0/0", s_req_ready,
                  s_tag_ready);
      end
      s_req_valid = 1'b0;
      s_tag_valid = 1'b0;
      alloc_core_ready = 1'b1;
   endtask

   task automatic test_basic();
      m_rdreq_ready = 1'b0;
      do_issue(5'd3, 32'h1000, 10'd16, 16'hABCD);
      total++;
      if (m_rdreq_valid !== 1'b1 || m_rdreq_tag !== 5'd3 || outstanding !== 6'd1) begin
         bad++;
         $display("FAIL issue_latency: valid=%0d tag=%0d outstanding=%0d, want 1/3/1",
                  m_rdreq_valid, m_rdreq_tag, outstanding);
      end
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (m_rdreq_valid !== 1'b1 || m_rdreq_addr !== 32'h1000 || m_rdreq_len !== 10'd16) begin
         bad++;
         $display("FAIL rdreq_hold: valid=%0d addr=%h len=%0d, want 1/1000/16", m_rdreq_valid,
                  m_rdreq_addr, m_rdreq_len);
      end
      m_rdreq_ready = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (m_rdreq_valid !== 1'b0) begin
         bad++;
         $display("FAIL rdreq_drop: valid=%0d, want 0", m_rdreq_valid);
      end
      do_cpl(5'd3, 10'd4);
      do_cpl(5'd3, 10'd4);
      total++;
      if (m_tag_free_valid !== 1'b0 || m_done_valid !== 1'b0 || outstanding !== 6'd1) begin
         bad++;
         $display("FAIL partial_quiet: free=%0d done=%0d outstanding=%0d, want 0/0/1",
                  m_tag_free_valid, m_done_valid, outstanding);
      end
      free_sb.push_back(5'd3);
      done_sb.push_back({5'd3, 16'hABCD, 1'b0});
      do_cpl(5'd3, 10'd8);
      total++;
      if (m_tag_free_valid !== 1'b1 || m_done_valid !== 1'b1 || outstanding !== 6'd0) begin
         bad++;
         $display("FAIL final_out: free=%0d done=%0d outstanding=%0d, want 1/1/0",
                  m_tag_free_valid, m_done_valid, outstanding);
      end
   endtask

   task automatic test_len_max();
      do_issue(5'd7, 32'h2000, 10'd0, 16'h7777);
      do_cpl(5'd7, 10'd512);
      total++;
      if (m_tag_free_valid !== 1'b0 || m_done_valid !== 1'b0 || outstanding !== 6'd1) begin
         bad++;
         $display("FAIL maxlen_partial: free=%0d done=%0d outstanding=%0d, want 0/0/1",
                  m_tag_free_valid, m_done_valid, outstanding);
      end
      free_sb.push_back(5'd7);
      done_sb.push_back({5'd7, 16'h7777, 1'b0});
      do_cpl(5'd7, 10'd512);
      total++;
      if (m_done_valid !== 1'b1 || outstanding !== 6'd0) begin
         bad++;
         $display("FAIL maxlen_final: done=%0d outstanding=%0d, want 1/0", m_done_valid,
                  outstanding);
      end
   endtask

   task automatic test_unexpected();
      do_cpl(5'd9, 10'd4);
      total++;
      if (err_unexpected !== 1'b1 || m_tag_free_valid !== 1'b0 || m_done_valid !== 1'b0 ||
          outstanding !== 6'd0) begin
         bad++;
         $display("FAIL unexpected_pulse: err=%0d free=%0d done=%0d outstanding=%0d, want 1/0/0/0",
                  err_unexpected, m_tag_free_valid, m_done_valid, outstanding);
      end
      @(posedge clk);
      #1;
      total++;
      if (err_unexpected !== 1'b0) begin
         bad++;
         $display("FAIL unexpected_width: err=%0d, want 0", err_unexpected);
      end
   endtask

   task automatic test_overrun();
      do_issue(5'd2, 32'h3000, 10'd8, 16'h2222);
      free_sb.push_back(5'd2);
      done_sb.push_back({5'd2, 16'h2222, 1'b1});
      do_cpl(5'd2, 10'd12);
      total++;
      if (err_overrun !== 1'b1 || err_unexpected !== 1'b0 || outstanding !== 6'd0) begin
         bad++;
         $display("FAIL overrun_pulse: ovr=%0d unexp=%0d outstanding=%0d, want 1/0/0",
                  err_overrun, err_unexpected, outstanding);
      end
      @(posedge clk);
      #1;
      total++;
      if (err_overrun !== 1'b0) begin
         bad++;
         $display("FAIL overrun_width: ovr=%0d, want 0", err_overrun);
      end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      do_issue(5'd4, 32'h4000, 10'd1, 16'h0404);
      do_issue(5'd5, 32'h5000, 10'd1, 16'h0505);
      m_tag_free_ready = 1'b0;
      free_sb.push_back(5'd4);
      done_sb.push_back({5'd4, 16'h0404, 1'b0});
      do_cpl(5'd4, 10'd1);
      free_sb.push_back(5'd5);
      done_sb.push_back({5'd5, 16'h0505, 1'b0});
      s_cpl_tag   = 5'd5;
      s_cpl_len   = 10'd1;
      s_cpl_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         total++;
         if (s_cpl_ready !== 1'b0) begin
            bad++;
            $display("FAIL cpl_backpressure: cpl_ready=%0d, want 0", s_cpl_ready);
         end
      end
      @(posedge clk);
      #1;
      m_tag_free_ready = 1'b1;
      @(negedge clk);
      while (!s_cpl_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      total++;
      if (s_cpl_ready !== 1'b1) begin
         bad++;
         $display("FAIL cpl_resume: cpl_ready=%0d, want 1", s_cpl_ready);
      end
      @(posedge clk);
      #1;
      s_cpl_valid = 1'b0;
      total++;
      if (m_tag_free_valid !== 1'b1 || m_tag_free_data !== 5'd5 || outstanding !== 6'd0) begin
         bad++;
         $display("FAIL second_final: free=%0d tag=%0d outstanding=%0d, want 1/5/0",
                  m_tag_free_valid, m_tag_free_data, outstanding);
      end
      // Issue tag 11 in the same cycle that tag 10 completes.
      do_issue(5'd10, 32'hA000, 10'd1, 16'h0A0A);
      free_sb.push_back(5'd10);
      done_sb.push_back({5'd10, 16'h0A0A, 1'b0});
      s_tag_data  = 5'd11;
      s_req_addr  = 32'hB000;
      s_req_len   = 10'd1;
      s_req_ctx   = 16'h0B0B;
      s_req_valid = 1'b1;
      s_tag_valid = 1'b1;
      s_cpl_tag   = 5'd10;
      s_cpl_len   = 10'd1;
      s_cpl_valid = 1'b1;
      @(negedge clk);
      total++;
      if (s_req_ready !== 1'b1 || s_cpl_ready !== 1'b1) begin
         bad++;
         $display("FAIL same_cycle_ready: req=%0d cpl=%0d, want 1/1", s_req_ready, s_cpl_ready);
      end else begin
         rdreq_sb.push_back({5'd11, 32'hB000, 10'd1});
      end
      @(posedge clk);
      #1;
      s_req_valid = 1'b0;
      s_tag_valid = 1'b0;
      s_cpl_valid = 1'b0;
      total++;
      if (outstanding !== 6'd1) begin
         bad++;
         $display("FAIL same_cycle_count: outstanding=%0d, want 1", outstanding);
      end
      free_sb.push_back(5'd11);
      done_sb.push_back({5'd11, 16'h0B0B, 1'b0});
      do_cpl(5'd11, 10'd1);
      total++;
      if (outstanding !== 6'd0) begin
         bad++;
         $display("FAIL drain_count: outstanding=%0d, want 0", outstanding);
      end
   endtask

   task automatic test_reset_discard();
      do_issue(5'd6, 32'h6000, 10'd4, 16'h0606);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      total++;
      if (outstanding !== 6'd0 || m_rdreq_valid !== 1'b0) begin
         bad++;
         $display("FAIL discard_state: outstanding=%0d rdreq_valid=%0d, want 0/0", outstanding,
                  m_rdreq_valid);
      end
      do_cpl(5'd6, 10'd4);
      total++;
      if (err_unexpected !== 1'b1 || m_done_valid !== 1'b0) begin
         bad++;
         $display("FAIL discard_cpl: err=%0d done=%0d, want 1/0", err_unexpected, m_done_valid);
      end
   endtask

   initial begin
      #1;
      test_reset();
      @(posedge clk);
      #1;
      test_basic();
      test_len_max();
      test_unexpected();
      test_overrun();
      test_back_to_back();
      test_reset_discard();
      for (int i = 0; i < 20; i++) begin
         if (rdreq_sb.size() == 0 && free_sb.size() == 0 && done_sb.size() == 0) break;
         @(posedge clk);
      end
      #1;
      total++;
      if (rdreq_sb.size() != 0 || free_sb.size() != 0 || done_sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: left rdreq=%0d free=%0d done=%0d, want 0/0/0",
                  rdreq_sb.size(), free_sb.size(), done_sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule
